seven_seg_scanner: RTL and testbench

- Parametrised multiplexed seven-segment driver; successor to the fixed 8-digit scan FSM.
- Scans `N_DIGITS` common-anode digits at a programmable refresh rate and applies PWM brightness to each digit slot.
- Display data is double-buffered behind a load handshake, so a new value only appears at a frame boundary and never tears mid-scan.
- Sits between the time/number-conversion logic and the board anode/cathode pins.

---
 rtl/seven_seg_scanner.sv | 174 +++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed common-anode seven-segment driver with
// per-slot PWM brightness and a frame-aligned double-buffered load path.
// Optional leading-zero blanking is compiled in when SEVEN_SEG_LZB_EN is defined.
// After reset the first slot is a dark lead-in slot, so digit 0 (and the
// first frame_start) arrives DIV cycles after reset release.
module seven_seg_scanner #(
   parameter int N_DIGITS = 8,
   parameter int CLK_HZ   = 100000000,
   parameter int SCAN_HZ  = 1000,
   parameter int BRIGHT_W = 3
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [4*N_DIGITS-1:0] digits_in,
   input  logic [N_DIGITS-1:0]   points_in,
   input  logic [N_DIGITS-1:0]   blank_in,
   input  logic                  load,
   output logic                  load_ack,
   input  logic [BRIGHT_W-1:0]   brightness,
   output logic [7:0]            cathode,
   output logic [N_DIGITS-1:0]   anode,
   output logic                  frame_start
);

   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int CW  = $clog2(DIV);
   localparam int OW  = CW + 1;
   localparam int IW  = $clog2(N_DIGITS);
   localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);
   localparam logic [OW-1:0] DIV_OW   = OW'(DIV);
   localparam logic [OW-1:0] STEP_OW  = OW'(DIV >> BRIGHT_W);

   // Active-low g..a pattern for a hex nibble.
   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic                  run_q, run_d;
   logic                  pend_q, pend_d;
   logic [4*N_DIGITS-1:0] stg_dig_q, stg_dig_d, shd_dig_q, shd_dig_d;
   logic [N_DIGITS-1:0]   stg_pt_q, stg_pt_d, shd_pt_q, shd_pt_d;
   logic [N_DIGITS-1:0]   stg_bl_q, stg_bl_d, shd_bl_q, shd_bl_d;
   logic [N_DIGITS-1:0]   anode_q, anode_d;
   logic [7:0]            cathode_q, cathode_d;
   logic                  load_ack_q, load_ack_d;
   logic                  frame_start_q, frame_start_d;
   logic                  tick, boundary, commit;
   logic [N_DIGITS-1:0]   lz;
   logic [OW-1:0]         on_cnt;
   logic [3:0]            nib;
   logic                  dark;

   // Slot counter, digit index and load/commit handshake next-state.
   always_comb begin
      tick     = (cnt_q == LAST_CNT);
      // The lead-in tick after reset counts as a frame boundary: digit 0 starts there.
      boundary = tick && (!run_q || (idx_q == LAST_IDX));
      commit   = boundary && pend_q;
      cnt_d    = tick ? '0 : cnt_q + CW'(1);
      idx_d    = idx_q;
      run_d    = run_q;
      if (tick) begin
         run_d = 1'b1;
         if (run_q) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
      end
      stg_dig_d = stg_dig_q;
      stg_pt_d  = stg_pt_q;
      stg_bl_d  = stg_bl_q;
      if (load) begin
         stg_dig_d = digits_in;
         stg_pt_d  = points_in;
         stg_bl_d  = blank_in;
      end
      // A load coinciding with a commit re-arms pend for the next frame.
      if (commit)    pend_d = load;
      else if (load) pend_d = 1'b1;
      else           pend_d = pend_q;
      shd_dig_d = commit ? stg_dig_q : shd_dig_q;
      shd_pt_d  = commit ? stg_pt_q  : shd_pt_q;
      shd_bl_d  = commit ? stg_bl_q  : shd_bl_q;
   end

`ifdef SEVEN_SEG_LZB_EN
   logic lz_run;
   // Leading-zero mask: a digit is dark when it and all digits above it are zero.
   always_comb begin
      lz     = '0;
      lz_run = 1'b1;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         lz_run = lz_run & (shd_dig_d[4*i +: 4] == 4'h0);
         lz[i]  = lz_run;
      end
   end
`else
   // Leading-zero blanking not built: no digit is masked.
   always_comb lz = '0;
`endif

   // Registered output decode from next-state so outputs line up with cnt_q.
   always_comb begin
      on_cnt = (&brightness) ? DIV_OW : (OW'(brightness) + OW'(1)) * STEP_OW;
      nib    = shd_dig_d[4*int'(idx_d) +: 4];
      dark   = shd_bl_d[idx_d] | lz[idx_d];
      anode_d = '1;
      if (run_d && !dark && ({1'b0, cnt_d} < on_cnt)) anode_d[idx_d] = 1'b0;
      if (!run_d || dark || (cnt_d == '0)) cathode_d = 8'hFF;
      else cathode_d = {~shd_pt_d[idx_d], hex_glyph(nib)};
      load_ack_d    = commit;
      frame_start_d = boundary;
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         run_q         <= 1'b0;
         pend_q        <= 1'b0;
         stg_dig_q     <= '0;
         stg_pt_q      <= '0;
         stg_bl_q      <= '0;
         shd_dig_q     <= '0;
         shd_pt_q      <= '0;
         shd_bl_q      <= '0;
         anode_q       <= '1;
         cathode_q     <= 8'hFF;
         load_ack_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         run_q         <= run_d;
         pend_q        <= pend_d;
         stg_dig_q     <= stg_dig_d;
         stg_pt_q      <= stg_pt_d;
         stg_bl_q      <= stg_bl_d;
         shd_dig_q     <= shd_dig_d;
         shd_pt_q      <= shd_pt_d;
         shd_bl_q      <= shd_bl_d;
         anode_q       <= anode_d;
         cathode_q     <= cathode_d;
         load_ack_q    <= load_ack_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign anode       = anode_q;
   assign cathode     = cathode_q;
   assign load_ack    = load_ack_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: N_DIGITS=4, DIV=8, BRIGHT_W=3.
// Cycle 0 is the cycle right after reset release (cnt=0); frames start at 8+32k.
module tb_seven_seg_scanner;

   localparam int N = 4;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [4*N-1:0] digits_in;
   logic [N-1:0]  points_in;
   logic [N-1:0]  blank_in;
   logic          load;
   logic          load_ack;
   logic [2:0]    brightness;
   logic [7:0]    cathode;
   logic [N-1:0]  anode;
   logic          frame_start;

   int total = 0;
   int passed = 0;
   int cyc = 0;
   int ack_cnt = 0;
   int ack0;
   logic [3:0] exp_an;

   seven_seg_scanner #(.N_DIGITS(N), .CLK_HZ(16), .SCAN_HZ(2), .BRIGHT_W(3)) dut (
      .clock(clock), .reset_n(reset_n), .digits_in(digits_in), .points_in(points_in),
      .blank_in(blank_in), .load(load), .load_ack(load_ack), .brightness(brightness),
      .cathode(cathode), .anode(anode), .frame_start(frame_start)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      #1;
      if (load_ack === 1'b1) ack_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
      cyc++;
   endtask

   task automatic goto(input int t);
      while (cyc < t) step();
   endtask

   task automatic ld(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
      digits_in = d;
      points_in = p;
      blank_in  = b;
      load      = 1'b1;
      step();
      load      = 1'b0;
   endtask

   initial begin
      reset_n = 1'b1; digits_in = '0; points_in = '0; blank_in = '0;
      load = 1'b0; brightness = 3'd7;
      #1 reset_n = 1'b0;
      @(negedge clock); @(negedge clock);
      check("rst_anode", anode, 4'hF);
      check("rst_cathode", cathode, 8'hFF);
      check("rst_ack", load_ack, 1'b0);
      check("rst_frame", frame_start, 1'b0);
      reset_n = 1'b1;
      cyc = 0;

      // Reset scan: lead-in slot dark, then digit 0..3 each for 8 cycles.
      goto(1);
      check("leadin_anode", anode, 4'hF);
      goto(8);
      check("first_frame", frame_start, 1'b1);
      check("first_anode", anode, 4'hE);
      check("first_cath_blank", cathode, 8'hFF);
      for (int c = 9; c < 40; c++) begin
         goto(c);
         exp_an = ~(4'b0001 << ((c - 8) / 8));
         check("scan_anode", anode, exp_an);
         check("scan_cath", cathode, ((c % 8) == 0) ? 8'hFF : 8'hC0);
         if (c == 9) check("frame_pulse_end", frame_start, 1'b0);
      end
      goto(40);
      check("second_frame", frame_start, 1'b1);

      // Deferred commit.
      goto(50);
      ack0 = ack_cnt;
      ld(16'h12AF, 4'h0, 4'h0);
      goto(65);
      check("defer_old_glyph", cathode, 8'hC0);
      check("defer_no_ack", load_ack, 1'b0);
      goto(72);
      check("commit_frame", frame_start, 1'b1);
      check("commit_ack", load_ack, 1'b1);
      goto(73);
      check("d0_F", cathode, 8'h8E);
      check("ack_pulse_end", load_ack, 1'b0);
      goto(97);
      check("d3_anode", anode, 4'h7);
      check("d3_1", cathode, 8'hF9);
      check("one_ack", ack_cnt - ack0, 1);

      // Double load before a boundary.
      goto(80);
      ack0 = ack_cnt;
      ld(16'h1111, 4'h0, 4'h0);
      goto(90);
      ld(16'h2222, 4'h0, 4'h0);
      goto(104);
      check("dbl_ack", load_ack, 1'b1);
      goto(105);
      check("dbl_glyph", cathode, 8'hA4);
      goto(129);
      check("dbl_d3", cathode, 8'hA4);
      check("dbl_one_ack", ack_cnt - ack0, 1);

      // Load on the committing tick.
      goto(120);
      ld(16'h3333, 4'h0, 4'h0);
      goto(135);
      ack0 = ack_cnt;
      ld(16'h4444, 4'h0, 4'h0);
      check("coll_ack1", load_ack, 1'b1);
      goto(137);
      check("coll_old", cathode, 8'hB0);
      goto(167);
      check("coll_mid_acks", ack_cnt - ack0, 1);
      goto(168);
      check("coll_ack2", load_ack, 1'b1);
      goto(169);
      check("coll_new", cathode, 8'h99);

      // PWM: brightness 1 lights each anode for cnt 0..1.
      goto(170);
      brightness = 3'd1;
      for (int c = 200; c < 232; c++) begin
         goto(c);
         exp_an = (((c - 200) % 8) < 2) ? ~(4'b0001 << ((c - 200) / 8)) : 4'hF;
         check("pwm_anode", anode, exp_an);
      end
      brightness = 3'd7;

      // Explicit blanking of digit 2, dp on digit 1.
      goto(240);
      ld(16'h4444, 4'b0010, 4'b0100);
      goto(264);
      check("blank_ack", load_ack, 1'b1);
      goto(273);
      check("blank_d1_anode", anode, 4'hD);
      check("blank_d1_dp", cathode, 8'h19);
      for (int c = 280; c < 288; c++) begin
         goto(c);
         check("blank_d2", anode, 4'hF);
      end
      goto(289);
      check("blank_d3", anode, 4'h7);
      goto(296);
      check("blank_frame", frame_start, 1'b1);

      // Leading zeros.
      goto(300);
      ld(16'h0050, 4'h0, 4'h0);
      goto(329);
      check("lz_d0", anode, 4'hE);
      goto(337);
      check("lz_d1", anode, 4'hD);
      check("lz_d1_glyph", cathode, 8'h92);
`ifdef SEVEN_SEG_LZB_EN
      goto(345);
      check("lz_d2", anode, 4'hF);
      goto(353);
      check("lz_d3", anode, 4'hF);
`else
      goto(345);
      check("lz_d2", anode, 4'hB);
      goto(353);
      check("lz_d3", anode, 4'h7);
`endif
      goto(360);
      ld(16'h0000, 4'h0, 4'h0);
      goto(393);
      check("zero_d0", anode, 4'hE);
`ifdef SEVEN_SEG_LZB_EN
      goto(401);
      check("zero_d1", anode, 4'hF);
      goto(409);
      check("zero_d2", anode, 4'hF);
      goto(417);
      check("zero_d3", anode, 4'hF);
`else
      goto(401);
      check("zero_d1", anode, 4'hD);
      goto(409);
      check("zero_d2", anode, 4'hB);
      goto(417);
      check("zero_d3", anode, 4'h7);
`endif

      // Reset while a load is pending.
      goto(410);
      ld(16'h7777, 4'h0, 4'h0);
      goto(425);
      check("pre_rst_glyph", cathode, 8'hF8);
      goto(430);
      ld(16'h8888, 4'h0, 4'h0);
      goto(440);
      ack0 = ack_cnt;
      reset_n = 1'b0;
      step(); step();
      check("mid_rst_anode", anode, 4'hF);
      check("mid_rst_cath", cathode, 8'hFF);
      check("mid_rst_ack", load_ack, 1'b0);
      reset_n = 1'b1;
      cyc = 0;
      goto(1);
      check("post_rst_leadin", anode, 4'hF);
      goto(8);
      check("post_rst_frame", frame_start, 1'b1);
      check("post_rst_no_ack", load_ack, 1'b0);
      check("post_rst_anode", anode, 4'hE);
      goto(9);
      check("post_rst_zero", cathode, 8'hC0);
      goto(41);
      check("post_rst_zero2", cathode, 8'hC0);
      goto(42);
      check("post_rst_acks", ack_cnt - ack0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
